// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings for the TP3 calculator blocks
package calc_pkg;

  typedef enum logic [2:0] {
    S_OP1    = 3'd0,
    S_OP2    = 3'd1,
    S_EXEC   = 3'd2,
    S_RESULT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  // Only called with A/B/C; anything else falls through to multiply.
  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    case (key)
      KEY_ADD: key_to_op = OP_ADD;
      KEY_SUB: key_to_op = OP_SUB;
      default: key_to_op = OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - rising-edge detector; history resets high so a level
// already asserted at reset release produces no pulse
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b1;
    else        prev <= sig;
  end

  assign pulse = sig & ~prev;

endmodule

// File: rtl/control_calculadora.sv
// rtl/control_calculadora.sv - calculator sequencer: operand entry, ALU launch
// and display selection
module control_calculadora
  import calc_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  alu_done,
  input  logic [4*N_DIGITS-1:0] alu_result,
  output logic                  alu_start,
  output logic [1:0]            alu_op,
  output logic [4*N_DIGITS-1:0] alu_a,
  output logic [4*N_DIGITS-1:0] alu_b,
  output logic [4*N_DIGITS-1:0] disp_value,
  output logic                  busy,
  output logic                  error
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] DMAX = CW'(N_DIGITS);
  localparam logic [TW-1:0] TMAX = TW'(ALU_TIMEOUT);

  state_t        state;
  logic [W-1:0]  op1, op2, res;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic          key_event, is_digit, is_op, clear_key, can_shift;

  detector_flanco u_detector_flanco (
    .clk   (clk),
    .reset (reset),
    .sig   (key_valid),
    .pulse (key_event)
  );

  assign is_digit  = key_event && (key_code <= 4'd9);
  assign is_op     = key_event && (key_code inside {KEY_ADD, KEY_SUB, KEY_MUL});
  assign clear_key = key_event && (key_code == KEY_CLR);
  assign can_shift = is_digit && (cnt < DMAX);

  // Clear key restores the reset image; key history lives in the detector.
  always_ff @(posedge clk) begin
    if (!reset || clear_key) begin
      state     <= S_OP1;
      op1       <= '0;
      op2       <= '0;
      res       <= '0;
      cnt       <= '0;
      tmo       <= '0;
      alu_op    <= OP_ADD;
      alu_start <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_OP1: begin
          if (can_shift) begin
            op1 <= {op1[W-5:0], key_code};
            cnt <= cnt + CW'(1);
          end else if (is_op) begin
            alu_op <= key_to_op(key_code);
            cnt    <= '0;
            op2    <= '0;
            state  <= S_OP2;
          end
        end
        S_OP2: begin
          if (can_shift) begin
            op2 <= {op2[W-5:0], key_code};
            cnt <= cnt + CW'(1);
          end else if (is_op) begin
            alu_op <= key_to_op(key_code);
          end else if (key_event && key_code == KEY_EQ) begin
            alu_start <= 1'b1;
            tmo       <= '0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            res   <= alu_result;
            state <= S_RESULT;
          end else if (tmo == TMAX) begin
            state <= S_ERROR;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_RESULT: begin
          if (is_digit) begin
            op1   <= {{(W-4){1'b0}}, key_code};
            cnt   <= CW'(1);
            state <= S_OP1;
          end else if (is_op) begin
            op1    <= res;
            alu_op <= key_to_op(key_code);
            op2    <= '0;
            cnt    <= '0;
            state  <= S_OP2;
          end
        end
        S_ERROR: ;
        default: state <= S_OP1;
      endcase
    end
  end

  always_comb begin
    disp_value = op1;
    case (state)
      S_OP1:    disp_value = op1;
      S_OP2:    disp_value = op2;
      S_EXEC:   disp_value = op2;
      S_RESULT: disp_value = res;
      S_ERROR:  disp_value = {N_DIGITS{4'hE}};
      default:  disp_value = op1;
    endcase
  end

  assign alu_a = op1;
  assign alu_b = op2;
  assign busy  = (state == S_EXEC);
  assign error = (state == S_ERROR);

endmodule

// File: tb/tb_control_calculadora.sv
// tb/tb_control_calculadora.sv - scoreboard bench for control_calculadora
module tb_control_calculadora;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, disp_value;
  logic        busy, error;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } exp_t;
  exp_t exp_q[$];

  control_calculadora #(.N_DIGITS(4), .ALU_TIMEOUT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .disp_value (disp_value),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int m;
    m = n % 10000;
    if (m < 0) m = m + 10000;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] alu_model(input exp_t e);
    case (e.op)
      2'b00:   return int2bcd(bcd2int(e.a) + bcd2int(e.b));
      2'b01:   return int2bcd(bcd2int(e.a) - bcd2int(e.b));
      default: return int2bcd(bcd2int(e.a) * bcd2int(e.b));
    endcase
  endfunction

  // Returns at the negedge just after the edge that registers the event.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic exec_and_finish();
    exp_t e;
    logic [15:0] r;
    int n;
    press(4'hE);
    n = 0;
    while (alu_start !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    vectors++;
    if (alu_start !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_start_seen: got %b want 1", alu_start);
    end
    vectors++;
    if (alu_a !== e.a || alu_b !== e.b || alu_op !== e.op || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL launch_regs: got a=%h b=%h op=%b busy=%b want a=%h b=%h op=%b busy=1",
               alu_a, alu_b, alu_op, busy, e.a, e.b, e.op);
    end
    r = alu_model(e);
    @(negedge clk);
    vectors++;
    if (alu_start !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_start_width: got %b want 0", alu_start);
    end
    alu_result = r;
    alu_done   = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    vectors++;
    if (disp_value !== r || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL result_disp: got %h busy=%b want %h busy=0", disp_value, busy, r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; key_valid = 1'b1; key_code = 4'd5; alu_done = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (disp_value !== 16'h0 || busy !== 1'b0 || error !== 1'b0 || alu_start !== 1'b0 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: got disp=%h busy=%b err=%b start=%b op=%b want 0", disp_value, busy, error, alu_start, alu_op);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (disp_value !== 16'h0 || alu_a !== 16'h0) begin
      miscompares++;
      $display("FAIL held_through_reset: got disp=%h a=%h want 0000", disp_value, alu_a);
    end
  endtask

  task automatic test_entry();
    for (int d = 1; d <= 5; d++) press(4'(d));
    vectors++;
    if (disp_value !== 16'h1234 || alu_a !== 16'h1234) begin
      miscompares++;
      $display("FAIL five_digits: got disp=%h a=%h want 1234", disp_value, alu_a);
    end
    press(4'hA);
    vectors++;
    if (alu_op !== 2'b00 || disp_value !== 16'h0) begin
      miscompares++;
      $display("FAIL op_add: got op=%b disp=%h want 00 0000", alu_op, disp_value);
    end
    press(4'd7);
    vectors++;
    if (alu_b !== 16'h0007 || disp_value !== 16'h0007) begin
      miscompares++;
      $display("FAIL op2_entry: got b=%h disp=%h want 0007", alu_b, disp_value);
    end
    exp_q.push_back('{a: 16'h1234, b: 16'h0007, op: 2'b00});
    exec_and_finish();
  endtask

  task automatic test_chain();
    press(4'hB);
    vectors++;
    if (alu_a !== 16'h1241 || alu_op !== 2'b01 || disp_value !== 16'h0) begin
      miscompares++;
      $display("FAIL chain_op: got a=%h op=%b disp=%h want 1241 01 0000", alu_a, alu_op, disp_value);
    end
    press(4'd9);
    exp_q.push_back('{a: 16'h1241, b: 16'h0009, op: 2'b01});
    exec_and_finish();
  endtask

  task automatic test_op_replace();
    press(4'hF);
    press(4'd2);
    press(4'hA);
    press(4'd3);
    press(4'hA);
    press(4'hC);
    vectors++;
    if (alu_op !== 2'b10 || alu_b !== 16'h0003 || disp_value !== 16'h0003 || alu_a !== 16'h0002) begin
      miscompares++;
      $display("FAIL op_replace: got op=%b b=%h disp=%h a=%h want 10 0003 0003 0002", alu_op, alu_b, disp_value, alu_a);
    end
    exp_q.push_back('{a: 16'h0002, b: 16'h0003, op: 2'b10});
    exec_and_finish();
  endtask

  task automatic test_timeout();
    int n;
    press(4'hC);
    press(4'd4);
    press(4'hE);
    vectors++;
    if (alu_start !== 1'b1 || alu_a !== 16'h0006 || alu_b !== 16'h0004) begin
      miscompares++;
      $display("FAIL timeout_launch: got start=%b a=%h b=%h want 1 0006 0004", alu_start, alu_a, alu_b);
    end
    n = 0;
    while (error !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n < 250 || n > 260 || error !== 1'b1 || disp_value !== 16'hEEEE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: got %0d cycles err=%b disp=%h want ~256 1 EEEE", n, error, disp_value);
    end
    press(4'd5);
    @(negedge clk);
    alu_result = 16'h4321; alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    vectors++;
    if (error !== 1'b1 || disp_value !== 16'hEEEE) begin
      miscompares++;
      $display("FAIL error_sticky: got err=%b disp=%h want 1 EEEE", error, disp_value);
    end
    press(4'hF);
    vectors++;
    if (error !== 1'b0 || disp_value !== 16'h0 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_from_error: got err=%b disp=%h a=%h b=%h op=%b want all 0", error, disp_value, alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_clear_vs_done();
    press(4'd1);
    press(4'hB);
    press(4'd2);
    press(4'hE);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL exec_entry: got busy=%b want 1", busy);
    end
    @(negedge clk);
    key_code = 4'hF; key_valid = 1'b1; alu_result = 16'h9999; alu_done = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    vectors++;
    if (busy !== 1'b0 || error !== 1'b0 || disp_value !== 16'h0 || alu_a !== 16'h0 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_beats_done: got busy=%b err=%b disp=%h a=%h op=%b want 0", busy, error, disp_value, alu_a, alu_op);
    end
    press(4'd3);
    vectors++;
    if (alu_a !== 16'h0003 || disp_value !== 16'h0003) begin
      miscompares++;
      $display("FAIL after_clear_op1: got a=%h disp=%h want 0003", alu_a, disp_value);
    end
  endtask

  task automatic test_held_key();
    @(negedge clk);
    key_code = 4'd8; key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (alu_a !== 16'h0038) begin
      miscompares++;
      $display("FAIL held_key_once: got a=%h want 0038", alu_a);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_chain();
    test_op_replace();
    test_timeout();
    test_clear_vs_done();
    test_held_key();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
